demux_sel_sequencer: RTL and testbench
======================================

Name: demux_sel_sequencer

Overview:
- Upstream feeder for the 1-to-4 demultiplexer; owns the demux data bit and select.
- Accepts a stream of data bits on a valid/ready handshake and buffers them in a small FIFO.
- Issues each bit with a round-robin channel select that skips disabled channels.
- Drives `out_a`/`out_sel` directly into the demux `a`/`sel` inputs; `out_valid`/`out_ready` qualify each transfer.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DATA_W, 1: data width; 1 for the demux path, wider for reuse.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has data.
- in_data  in  DATA_W  upstream data.
- in_ready  out  1  FIFO can accept; equals !full.
- ch_en  in  4  per-channel enable mask; bit i enables sel value i.
- out_valid  out  1  `out_a`/`out_sel` hold a valid item.
- out_a  out  DATA_W  data to demux input a.
- out_sel  out  2  channel select to demux sel.
- out_ready  in  1  downstream consumes the item.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock (`clk`, rising edge). Reset `rst_n` is asynchronous and active-low.
- Reset state: FIFO empty, `fifo_cnt`=0, `in_ready`=1, `out_valid`=0, `out_a`=0, `out_sel`=0, `last_sel`=3. With `last_sel`=3, the first search starts at channel 0.
- Reset asserted mid-operation: all of the above is applied immediately. Buffered and presented items are discarded.
- FIFO write: `in_valid && in_ready` at a rising edge. Read and write pointers wrap modulo DEPTH.
- Full FIFO: `in_ready`=0 even when a read happens in the same cycle; there is no write-through on full.
- Empty FIFO: there is no bypass. Data written at edge E can be loaded into the output register at edge E+1 at the earliest. Minimum latency is 2 edges.
- FSM, 2 states:
  - IDLE: `out_valid`=0.
  - Load condition: at an edge with FIFO non-empty and `ch_en`!=0, pop the head into `out_a` and set `out_sel` = next enabled channel after `last_sel`. The search order is cyclic `last_sel`+1, +2, +3, +4 (mod 4), so `last_sel` itself is eligible last.
  - IDLE -> HOLD on load: set `out_valid`=1 and `last_sel`=`out_sel`.
  - HOLD: `out_a` and `out_sel` stay stable while `out_ready`=0.
  - HOLD, `out_ready`=1: if the load condition holds, back-to-back load (stay HOLD). Otherwise `out_valid`=0 and go to IDLE. `out_a`/`out_sel` keep their last values in IDLE.
- `ch_en`=0: no loads; items remain buffered; `in_ready` follows FIFO state. The item already presented in HOLD still completes normally.
- `ch_en` is sampled only at load time. Changing it while in HOLD does not alter the presented `out_sel`.
- Single enabled channel: every item goes to that channel.
- Simultaneous push and pop on a non-full FIFO: `fifo_cnt` is unchanged.
- `fifo_cnt` is always in 0..DEPTH.

Optional Feature:
- Macro: DSEQ_CNT_EN.
- When defined: adds output port `ch_cnt` (4x8 bits, packed 32). Each counter increments on a completed transfer (`out_valid && out_ready`) to channel `out_sel`. Counters saturate at 255 and reset to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package `dseq_pkg`:
  - localparams `CH_N`=4 and `SEL_W`=2.
  - FSM state typedef `{S_IDLE, S_HOLD}`.
  - Pure function `next_sel(last_sel, ch_en)` returning the next enabled channel.
- Sub-module `dseq_fifo`: synchronous DEPTH x DATA_W FIFO with push/pop/full/empty/count. Instantiated once. The sequencer top holds the FSM, the output register and the optional counters.

Test Plan:
- Reset, then push 1,0,1,1 with `ch_en`=4'b1111 and `out_ready`=1 -> `out_sel` 0,1,2,3 with `out_a` 1,0,1,1. The first `out_valid` rises 2 edges after the first push.
- `ch_en`=4'b1010, push 4 items -> `out_sel` sequence 1,3,1,3.
- Hold `out_ready`=0, push 5 items with DEPTH=4 -> one item presented and 4 buffered. `in_ready`=0, `fifo_cnt`=4, `out_a`/`out_sel` stable. Release `out_ready` -> all 5 drain in order.
- `ch_en`=0 with 2 items pushed -> `out_valid` stays 0 and `fifo_cnt`=2. Set `ch_en`=4'b0100 -> both items issue with `out_sel`=2.
- Assert `rst_n`=0 asynchronously mid-stream, between edges -> outputs go immediately to their reset values: `fifo_cnt`=0, `in_ready`=1. After release, the next item issues with `out_sel`=0.
- With DSEQ_CNT_EN defined: 300 transfers to channel 2 only -> `ch_cnt[2]` saturates at 255; the other counters stay 0.

Source files
------------

// File: rtl/demux_sel_sequencer_pkg.sv
// Shared definitions for the demux select sequencer: channel count, select
// width, FSM state encoding and the round-robin channel search.
package dseq_pkg;

   localparam int CH_N  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   // Search channels last_sel+1 .. last_sel+4 (mod 4) and return the first
   // enabled one. last_sel itself is examined last. If nothing is enabled
   // the result is last_sel, but callers never load with an empty mask.
   function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] last_sel,
                                                 input logic [CH_N-1:0]  ch_en);
      logic [SEL_W-1:0] idx;
      logic             found;
      next_sel = last_sel;
      found    = 1'b0;
      for (int k = 1; k <= CH_N; k++) begin
         idx = last_sel + SEL_W'(k);
         if (!found && ch_en[idx]) begin
            next_sel = idx;
            found    = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/demux_sel_sequencer_fifo.sv
// DEPTH x DATA_W synchronous FIFO feeding the sequencer output register.
// Pushes while full and pops while empty are ignored; the head entry is
// always visible on pop_data. Storage is not reset, only pointers and count.
module dseq_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full     = (cnt_q == CNT_FULL);
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Upstream feeder for the 1-to-4 demux: buffers incoming bits in a FIFO and
// presents each one with a round-robin select that skips disabled channels.
// Optional per-channel transfer counters (ch_cnt) are built when the macro
// DSEQ_CNT_EN is defined.
module demux_sel_sequencer
   import dseq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic [CH_N-1:0]          ch_en,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_a,
   output logic [SEL_W-1:0]         out_sel,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef DSEQ_CNT_EN
   ,
   output logic [CH_N*8-1:0]        ch_cnt
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] out_a_q, out_a_d;
   logic [SEL_W-1:0]  out_sel_q, out_sel_d;
   logic [SEL_W-1:0]  last_sel_q, last_sel_d;
   logic [SEL_W-1:0]  sel_nxt;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;
   logic              load_ok, pop;

   dseq_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_cnt)
   );

   // No write-through on full: readiness depends only on occupancy.
   assign in_ready  = !fifo_full;
   assign out_valid = (state_q == S_HOLD);
   assign out_a     = out_a_q;
   assign out_sel   = out_sel_q;
   assign load_ok   = !fifo_empty && (ch_en != '0);
   assign sel_nxt   = next_sel(last_sel_q, ch_en);

   // Next-state logic: load a new item when idle, or when the presented one
   // is consumed; otherwise hold out_a/out_sel steady.
   always_comb begin
      state_d    = state_q;
      out_a_d    = out_a_q;
      out_sel_d  = out_sel_q;
      last_sel_d = last_sel_q;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_ok) begin
               pop        = 1'b1;
               out_a_d    = fifo_head;
               out_sel_d  = sel_nxt;
               last_sel_d = sel_nxt;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               if (load_ok) begin
                  pop        = 1'b1;
                  out_a_d    = fifo_head;
                  out_sel_d  = sel_nxt;
                  last_sel_d = sel_nxt;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and output register; last_sel resets to 3 so the first search
   // starts at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         out_a_q    <= '0;
         out_sel_q  <= '0;
         last_sel_q <= SEL_W'(CH_N - 1);
      end else begin
         state_q    <= state_d;
         out_a_q    <= out_a_d;
         out_sel_q  <= out_sel_d;
         last_sel_q <= last_sel_d;
      end
   end

`ifdef DSEQ_CNT_EN
   logic [7:0] cnt_q [CH_N];
   logic [7:0] cnt_d [CH_N];

   // Saturating per-channel count of completed transfers.
   always_comb begin
      for (int i = 0; i < CH_N; i++) cnt_d[i] = cnt_q[i];
      if (out_valid && out_ready && (cnt_q[out_sel_q] != 8'hFF))
         cnt_d[out_sel_q] = cnt_q[out_sel_q] + 8'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < CH_N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Pack counters, channel 0 in the low byte.
   always_comb begin
      ch_cnt = '0;
      for (int i = 0; i < CH_N; i++) ch_cnt[i*8 +: 8] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed testbench for demux_sel_sequencer (DEPTH=4, DATA_W=1).
module tb_demux_sel_sequencer;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_data;
   logic       in_ready;
   logic [3:0] ch_en;
   logic       out_valid;
   logic       out_a;
   logic [1:0] out_sel;
   logic       out_ready;
   logic [2:0] fifo_cnt;
`ifdef DSEQ_CNT_EN
   logic [31:0] ch_cnt;
`endif

   int n_run  = 0;
   int n_fail = 0;

   logic       got_a   [$];
   logic [1:0] got_sel [$];

   demux_sel_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ch_en     (ch_en),
      .out_valid (out_valid),
      .out_a     (out_a),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .fifo_cnt  (fifo_cnt)
`ifdef DSEQ_CNT_EN
      ,
      .ch_cnt    (ch_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Record every transfer that will complete at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_a.push_back(out_a);
         got_sel.push_back(out_sel);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      got_a.delete();
      got_sel.delete();
   endtask

   // Push n items (bits[i] is item i), each held until accepted (bounded).
   task automatic push_items(input int n, input logic [7:0] bits);
      logic acc;
      int   guard;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = bits[i];
         guard    = 0;
         do begin
            acc = in_ready;
            cyc(1);
            guard++;
         end while (!acc && guard < 50);
         if (!acc) begin
            n_run++; n_fail++;
            $display("FAIL push_timeout item=%0d in_ready=%b required 1", i, in_ready);
         end
      end
      in_valid = 1'b0;
   endtask

   // Wait until n transfers are logged and the output has gone idle.
   task automatic wait_drain(input int n);
      int guard = 0;
      while (!(got_sel.size() >= n && !out_valid) && guard < 400) begin
         cyc(1);
         guard++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; ch_en = 4'b1111; out_ready = 1'b0;
      cyc(2);
      n_run++;
      if (fifo_cnt !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_a !== 1'b0 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state cnt=%0d rdy=%b vld=%b a=%b sel=%0d required 0 1 0 0 0",
                  fifo_cnt, in_ready, out_valid, out_a, out_sel);
      end
      @(negedge clk); rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_stream();
      logic       ea [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      clear_log();
      ch_en = 4'b1111; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 1'b1;
      cyc(1);
      n_run++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL latency_edge1 out_valid=%b required 0", out_valid);
      end
      in_data = 1'b0;
      cyc(1);
      n_run++;
      if (out_valid !== 1'b1 || out_a !== 1'b1 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL latency_edge2 vld=%b a=%b sel=%0d required 1 1 0", out_valid, out_a, out_sel);
      end
      in_data = 1'b1; cyc(1);
      in_data = 1'b1; cyc(1);
      in_valid = 1'b0;
      wait_drain(4);
      n_run++;
      if (got_sel.size() != 4) begin
         n_fail++; $display("FAIL stream_count got=%0d required 4", got_sel.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_run++;
         if (i >= got_sel.size()) begin
            n_fail++; $display("FAIL stream_item%0d missing required a=%b sel=%0d", i, ea[i], es[i]);
         end else if (got_a[i] !== ea[i] || got_sel[i] !== es[i]) begin
            n_fail++;
            $display("FAIL stream_item%0d a=%b sel=%0d required a=%b sel=%0d", i, got_a[i], got_sel[i], ea[i], es[i]);
         end
      end
   endtask

   task automatic test_mask_skip();
      logic       ea [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [1:0] es [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      clear_log();
      ch_en = 4'b1010; out_ready = 1'b1;
      push_items(4, 8'b0000_0110);
      wait_drain(4);
      n_run++;
      if (got_sel.size() != 4) begin
         n_fail++; $display("FAIL mask_count got=%0d required 4", got_sel.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_run++;
         if (i >= got_sel.size()) begin
            n_fail++; $display("FAIL mask_item%0d missing required a=%b sel=%0d", i, ea[i], es[i]);
         end else if (got_a[i] !== ea[i] || got_sel[i] !== es[i]) begin
            n_fail++;
            $display("FAIL mask_item%0d a=%b sel=%0d required a=%b sel=%0d", i, got_a[i], got_sel[i], ea[i], es[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic       ea [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      clear_log();
      ch_en = 4'b1111; out_ready = 1'b0;
      push_items(5, 8'b0001_1001);
      n_run++;
      if (in_ready !== 1'b0 || fifo_cnt !== 3'd4 || out_valid !== 1'b1 || out_a !== 1'b1 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL full_state rdy=%b cnt=%0d vld=%b a=%b sel=%0d required 0 4 1 1 0",
                  in_ready, fifo_cnt, out_valid, out_a, out_sel);
      end
      ch_en = 4'b0010;
      cyc(3);
      n_run++;
      if (out_valid !== 1'b1 || out_a !== 1'b1 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL hold_stable vld=%b a=%b sel=%0d required 1 1 0", out_valid, out_a, out_sel);
      end
      ch_en = 4'b1111;
      // Offer a sixth item while full and popping: it must be refused.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 1'b0;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_pop_ready in_ready=%b required 0", in_ready);
      end
      cyc(1);
      in_valid = 1'b0;
      wait_drain(5);
      n_run++;
      if (got_sel.size() != 5) begin
         n_fail++; $display("FAIL drain_count got=%0d required 5", got_sel.size());
      end
      for (int i = 0; i < 5; i++) begin
         n_run++;
         if (i >= got_sel.size()) begin
            n_fail++; $display("FAIL drain_item%0d missing required a=%b sel=%0d", i, ea[i], es[i]);
         end else if (got_a[i] !== ea[i] || got_sel[i] !== es[i]) begin
            n_fail++;
            $display("FAIL drain_item%0d a=%b sel=%0d required a=%b sel=%0d", i, got_a[i], got_sel[i], ea[i], es[i]);
         end
      end
   endtask

   task automatic test_mask_zero();
      clear_log();
      ch_en = 4'b0000; out_ready = 1'b1;
      push_items(2, 8'b0000_0001);
      cyc(4);
      n_run++;
      if (out_valid !== 1'b0 || fifo_cnt !== 3'd2 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mask_zero vld=%b cnt=%0d rdy=%b required 0 2 1", out_valid, fifo_cnt, in_ready);
      end
      ch_en = 4'b0100;
      wait_drain(2);
      n_run++;
      if (got_sel.size() != 2) begin
         n_fail++; $display("FAIL single_count got=%0d required 2", got_sel.size());
      end else if (got_a[0] !== 1'b1 || got_sel[0] !== 2'd2 || got_a[1] !== 1'b0 || got_sel[1] !== 2'd2) begin
         n_fail++;
         $display("FAIL single_items a=%b,%b sel=%0d,%0d required a=1,0 sel=2,2",
                  got_a[0], got_a[1], got_sel[0], got_sel[1]);
      end
   endtask

   task automatic test_async_reset();
      ch_en = 4'b1111; out_ready = 1'b0;
      push_items(3, 8'b0000_0011);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_run++;
      if (fifo_cnt !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_a !== 1'b0 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset cnt=%0d rdy=%b vld=%b a=%b sel=%0d required 0 1 0 0 0",
                  fifo_cnt, in_ready, out_valid, out_a, out_sel);
      end
      @(negedge clk); rst_n = 1'b1;
      cyc(1);
      clear_log();
      out_ready = 1'b1;
      push_items(1, 8'b0000_0001);
      wait_drain(1);
      n_run++;
      if (got_sel.size() != 1) begin
         n_fail++; $display("FAIL post_reset_count got=%0d required 1", got_sel.size());
      end else if (got_a[0] !== 1'b1 || got_sel[0] !== 2'd0) begin
         n_fail++;
         $display("FAIL post_reset_item a=%b sel=%0d required a=1 sel=0", got_a[0], got_sel[0]);
      end
   endtask

`ifdef DSEQ_CNT_EN
   task automatic test_counters();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      cyc(1);
      clear_log();
      ch_en = 4'b0100; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_data  = i[0];
         while (!in_ready) cyc(1);
         cyc(1);
      end
      in_valid = 1'b0;
      wait_drain(300);
      n_run++;
      if (ch_cnt[23:16] !== 8'd255 || ch_cnt[7:0] !== 8'd0 || ch_cnt[15:8] !== 8'd0 || ch_cnt[31:24] !== 8'd0) begin
         n_fail++;
         $display("FAIL ch_cnt_sat ch_cnt=%h required 00ff0000", ch_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_mask_skip();
      test_backpressure();
      test_mask_zero();
      test_async_reset();
`ifdef DSEQ_CNT_EN
      test_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
